// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_arbiter_pkg : shared width, grant ids and FSM encoding for the       |
// | data-memory arbiter.                                            rev 1.0  |
// +--------------------------------------------------------------------------+
package dmem_arbiter_pkg;
  localparam int ADDR_WIDTH = 32;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arb2 : 2-way round-robin picker, one-hot combinational grant.          |
// |                                                                 rev 1.0  |
// +--------------------------------------------------------------------------+
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);
  // On a tie the port that did not win last time takes the grant.
  assign gnt[0] = req[0] & (~req[1] | (last_gnt == GNT_B));
  assign gnt[1] = req[1] & (~req[0] | (last_gnt == GNT_A));
endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_arbiter : shares one data memory between the CPU (A) and a debug     |
// | master (B) with round-robin grants and fixed wait states.       rev 1.0  |
// +--------------------------------------------------------------------------+
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [ADDR_WIDTH-1:0] a_wdata,
  input  logic                  a_mode,
  output logic                  a_done,
  output logic [ADDR_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [ADDR_WIDTH-1:0] b_wdata,
  input  logic                  b_mode,
  output logic                  b_done,
  output logic [ADDR_WIDTH-1:0] b_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [ADDR_WIDTH-1:0] mem_wdata,
  output logic                  mem_mode,
  input  logic [ADDR_WIDTH-1:0] mem_rdata,
  output logic                  cpu_stall
);
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             winner;
  logic             last_gnt;
  logic             we_q;
  logic [1:0]       gnt;

  rr_arb2 u_arb (
    .req      ({b_req, a_req}),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      winner    <= GNT_A;
      last_gnt  <= GNT_B;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_mode  <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            cnt <= CNT_W'(MEM_LATENCY - 1);
            if (gnt[1]) begin
              winner    <= GNT_B;
              we_q      <= b_we;
              mem_addr  <= b_addr;
              mem_wdata <= b_wdata;
              mem_mode  <= b_mode;
            end else begin
              winner    <= GNT_A;
              we_q      <= a_we;
              mem_addr  <= a_addr;
              mem_wdata <= a_wdata;
              mem_mode  <= a_mode;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            // Stores leave the requester's rdata register untouched.
            if (!we_q) begin
              if (winner == GNT_B) b_rdata <= mem_rdata;
              else                 a_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DONE: last_gnt <= winner;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    a_done    = 1'b0;
    b_done    = 1'b0;
    case (state)
      ST_IDLE: if (|gnt) state_nx = ST_ACCESS;
      ST_ACCESS: begin
        mem_read  = ~we_q;
        mem_write = we_q;
        if (cnt == '0) state_nx = ST_DONE;
      end
      ST_DONE: begin
        a_done   = (winner == GNT_A);
        b_done   = (winner == GNT_B);
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign cpu_stall = a_req & ~a_done;
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_arbiter : vector table plus directed sequences for dmem_arbiter,  |
// | with latency-1 and latency-15 instances for the wait-state sweep. rev 1.0|
// +--------------------------------------------------------------------------+
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, a_mode = 1'b0;
  logic        b_req = 1'b0, b_we = 1'b0, b_mode = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0, mem_rdata = '0;

  logic        a_done, b_done, mem_read, mem_write, mem_mode, cpu_stall;
  logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata;
  logic        s1_a_done, s1_b_done, s1_mem_read, s1_mem_write, s1_mem_mode, s1_cpu_stall;
  logic [31:0] s1_a_rdata, s1_b_rdata, s1_mem_addr, s1_mem_wdata;
  logic        s15_a_done, s15_b_done, s15_mem_read, s15_mem_write, s15_mem_mode, s15_cpu_stall;
  logic [31:0] s15_a_rdata, s15_b_rdata, s15_mem_addr, s15_mem_wdata;

  int checks = 0;
  int failures = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_LATENCY(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_mode(a_mode),
    .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_mode(b_mode),
    .b_done(b_done), .b_rdata(b_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mode(mem_mode), .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  dmem_arbiter #(.MEM_LATENCY(1), .CNT_W(4)) dut_l1 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_mode(a_mode),
    .a_done(s1_a_done), .a_rdata(s1_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_mode(b_mode),
    .b_done(s1_b_done), .b_rdata(s1_b_rdata),
    .mem_read(s1_mem_read), .mem_write(s1_mem_write), .mem_addr(s1_mem_addr),
    .mem_wdata(s1_mem_wdata), .mem_mode(s1_mem_mode), .mem_rdata(mem_rdata),
    .cpu_stall(s1_cpu_stall)
  );

  dmem_arbiter #(.MEM_LATENCY(15), .CNT_W(4)) dut_l15 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_mode(a_mode),
    .a_done(s15_a_done), .a_rdata(s15_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_mode(b_mode),
    .b_done(s15_b_done), .b_rdata(s15_b_rdata),
    .mem_read(s15_mem_read), .mem_write(s15_mem_write), .mem_addr(s15_mem_addr),
    .mem_wdata(s15_mem_wdata), .mem_mode(s15_mem_mode), .mem_rdata(mem_rdata),
    .cpu_stall(s15_cpu_stall)
  );

  always @(negedge clk)
    if (rst && ((mem_read && mem_write) || (a_done && b_done))) overlap++;

  typedef struct {
    logic        rst, a_req, a_we, a_mode, b_req, b_we, b_mode;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata, mem_rdata;
    logic        e_rd, e_wr, e_mode, e_ad, e_bd, e_stall;
    logic [31:0] e_addr, e_wdata, e_ardata, e_brdata;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(
    input logic r, input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
    input logic am, input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd,
    input logic bm, input logic [31:0] md, input logic erd, input logic ewr, input logic [31:0] ea,
    input logic [31:0] ewd, input logic em, input logic ead, input logic ebd, input logic est,
    input logic [31:0] ear, input logic [31:0] ebr);
    vec_t x;
    x.rst = r; x.a_req = ar; x.a_we = aw; x.a_addr = aa; x.a_wdata = ad; x.a_mode = am;
    x.b_req = br; x.b_we = bw; x.b_addr = ba; x.b_wdata = bd; x.b_mode = bm; x.mem_rdata = md;
    x.e_rd = erd; x.e_wr = ewr; x.e_addr = ea; x.e_wdata = ewd; x.e_mode = em;
    x.e_ad = ead; x.e_bd = ebd; x.e_stall = est; x.e_ardata = ear; x.e_brdata = ebr;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_mode = 0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_mode = 0;
  endtask

  // Returns at the negedge of the done cycle, or flags a timeout.
  task automatic wait_done(input string name, input logic port_b, input int bound);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (port_b ? b_done : a_done) seen = 1'b1;
    end
    chk({name, " done within bound"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    // test 1: A load, latency 2
    vq.push_back(v(0, 0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0,0,0, 0,0,0, 0,0));
    vq.push_back(v(1, 1,0,32'h10,0,0, 0,0,0,0,0, 0, 0,0,0,0,0, 0,0,1, 0,0));
    vq.push_back(v(1, 1,0,32'h10,0,0, 0,0,0,0,0, 32'hDEADBEEF, 1,0,32'h10,0,0, 0,0,1, 0,0));
    vq.push_back(v(1, 1,0,32'h10,0,0, 0,0,0,0,0, 32'hDEADBEEF, 1,0,32'h10,0,0, 0,0,1, 0,0));
    vq.push_back(v(1, 1,0,32'h10,0,0, 0,0,0,0,0, 32'hDEADBEEF, 0,0,32'h10,0,0, 1,0,0, 32'hDEADBEEF,0));
    vq.push_back(v(1, 0,0,0,0,0, 0,0,0,0,0, 0, 0,0,32'h10,0,0, 0,0,0, 32'hDEADBEEF,0));
    // test 2: both store after reset, alternate A,B,A,B
    vq.push_back(v(0, 0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0,0,0, 0,0,0, 0,0));
    for (int k = 0; k < 2; k++) begin
      vq.push_back(v(1, 1,1,32'h100,32'h11111111,1, 1,1,32'h200,32'h22222222,0, 0,
                     0,0,(k==0)?32'h0:32'h200,(k==0)?32'h0:32'h22222222,0, 0,0,1, 0,0));
      vq.push_back(v(1, 1,1,32'h100,32'h11111111,1, 1,1,32'h200,32'h22222222,0, 0, 1'b0,1'b1,32'h100,32'h11111111,1, 0,0,1, 0,0));
      vq.push_back(v(1, 1,1,32'h100,32'h11111111,1, 1,1,32'h200,32'h22222222,0, 0, 1'b0,1'b1,32'h100,32'h11111111,1, 0,0,1, 0,0));
      vq.push_back(v(1, 1,1,32'h100,32'h11111111,1, 1,1,32'h200,32'h22222222,0, 0, 0,0,32'h100,32'h11111111,1, 1,0,0, 0,0));
      vq.push_back(v(1, 1,1,32'h100,32'h11111111,1, 1,1,32'h200,32'h22222222,0, 0, 0,0,32'h100,32'h11111111,1, 0,0,1, 0,0));
      vq.push_back(v(1, 1,1,32'h100,32'h11111111,1, 1,1,32'h200,32'h22222222,0, 0, 0,1,32'h200,32'h22222222,0, 0,0,1, 0,0));
      vq.push_back(v(1, 1,1,32'h100,32'h11111111,1, 1,1,32'h200,32'h22222222,0, 0, 0,1,32'h200,32'h22222222,0, 0,0,1, 0,0));
      vq.push_back(v(1, 1,1,32'h100,32'h11111111,1, 1,1,32'h200,32'h22222222,0, 0, 0,0,32'h200,32'h22222222,0, 0,1,1, 0,0));
    end
    // test 3: B store 0x55 to 0x20, then A load from 0x20
    vq.push_back(v(1, 0,0,0,0,0, 0,0,0,0,0, 0, 0,0,32'h200,32'h22222222,0, 0,0,0, 0,0));
    vq.push_back(v(1, 0,0,0,0,0, 1,1,32'h20,32'h55,1, 0, 0,0,32'h200,32'h22222222,0, 0,0,0, 0,0));
    vq.push_back(v(1, 0,0,0,0,0, 1,1,32'h20,32'h55,1, 0, 0,1,32'h20,32'h55,1, 0,0,0, 0,0));
    vq.push_back(v(1, 0,0,0,0,0, 1,1,32'h20,32'h55,1, 0, 0,1,32'h20,32'h55,1, 0,0,0, 0,0));
    vq.push_back(v(1, 0,0,0,0,0, 1,1,32'h20,32'h55,1, 0, 0,0,32'h20,32'h55,1, 0,1,0, 0,0));
    vq.push_back(v(1, 1,0,32'h20,0,0, 0,0,0,0,0, 0, 0,0,32'h20,32'h55,1, 0,0,1, 0,0));
    vq.push_back(v(1, 1,0,32'h20,0,0, 0,0,0,0,0, 32'h55, 1,0,32'h20,0,0, 0,0,1, 0,0));
    vq.push_back(v(1, 1,0,32'h20,0,0, 0,0,0,0,0, 32'h55, 1,0,32'h20,0,0, 0,0,1, 0,0));
    vq.push_back(v(1, 1,0,32'h20,0,0, 0,0,0,0,0, 0, 0,0,32'h20,0,0, 1,0,0, 32'h55,0));
    vq.push_back(v(1, 0,0,0,0,0, 0,0,0,0,0, 0, 0,0,32'h20,0,0, 0,0,0, 32'h55,0));

    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      rst = vq[i].rst;
      a_req = vq[i].a_req; a_we = vq[i].a_we; a_addr = vq[i].a_addr;
      a_wdata = vq[i].a_wdata; a_mode = vq[i].a_mode;
      b_req = vq[i].b_req; b_we = vq[i].b_we; b_addr = vq[i].b_addr;
      b_wdata = vq[i].b_wdata; b_mode = vq[i].b_mode; mem_rdata = vq[i].mem_rdata;
      @(negedge clk);
      chk($sformatf("v%0d mem_read", i), {31'd0, mem_read}, {31'd0, vq[i].e_rd});
      chk($sformatf("v%0d mem_write", i), {31'd0, mem_write}, {31'd0, vq[i].e_wr});
      chk($sformatf("v%0d mem_addr", i), mem_addr, vq[i].e_addr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vq[i].e_wdata);
      chk($sformatf("v%0d mem_mode", i), {31'd0, mem_mode}, {31'd0, vq[i].e_mode});
      chk($sformatf("v%0d a_done", i), {31'd0, a_done}, {31'd0, vq[i].e_ad});
      chk($sformatf("v%0d b_done", i), {31'd0, b_done}, {31'd0, vq[i].e_bd});
      chk($sformatf("v%0d cpu_stall", i), {31'd0, cpu_stall}, {31'd0, vq[i].e_stall});
      chk($sformatf("v%0d a_rdata", i), a_rdata, vq[i].e_ardata);
      chk($sformatf("v%0d b_rdata", i), b_rdata, vq[i].e_brdata);
    end

    // test 4: reset in the first ACCESS cycle of a B grant
    step();
    rst = 0; clear_inputs();
    step();
    rst = 1; a_req = 1; a_addr = 32'h40; mem_rdata = 32'h12345678;
    wait_done("t4 warmup", 1'b0, 10);
    step();
    b_req = 1; b_we = 1; b_addr = 32'h80; b_wdata = 32'hAA;
    step();
    @(negedge clk);
    chk("t4 b write before reset", {31'd0, mem_write}, 32'd1);
    chk("t4 b addr before reset", mem_addr, 32'h80);
    #2 rst = 0;
    #1;
    chk("t4 write async clear", {31'd0, mem_write}, 32'd0);
    chk("t4 read async clear", {31'd0, mem_read}, 32'd0);
    chk("t4 b_done async clear", {31'd0, b_done}, 32'd0);
    chk("t4 addr async clear", mem_addr, 32'h0);
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("t4 idle after release", {31'd0, mem_read | mem_write}, 32'd0);
    step();
    @(negedge clk);
    chk("t4 A wins after reset", {31'd0, mem_read}, 32'd1);
    chk("t4 A addr after reset", mem_addr, 32'h40);
    wait_done("t4 A", 1'b0, 10);
    chk("t4 a_rdata", a_rdata, 32'h12345678);
    step();
    clear_inputs();

    // test 5: A drops req mid-access, B pending
    a_req = 1; a_addr = 32'h44;
    step();
    a_req = 0; b_req = 1; b_we = 1; b_addr = 32'h88; b_wdata = 32'hBB; mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    chk("t5 read c1", {31'd0, mem_read}, 32'd1);
    chk("t5 stall follows a_req", {31'd0, cpu_stall}, 32'd0);
    step();
    @(negedge clk);
    chk("t5 read c2", {31'd0, mem_read}, 32'd1);
    step();
    @(negedge clk);
    chk("t5 a_done", {31'd0, a_done}, 32'd1);
    chk("t5 a_rdata", a_rdata, 32'h0BADF00D);
    step();
    @(negedge clk);
    chk("t5 idle gap", {31'd0, mem_read | mem_write}, 32'd0);
    step();
    @(negedge clk);
    chk("t5 B granted", {31'd0, mem_write}, 32'd1);
    chk("t5 B addr", mem_addr, 32'h88);
    wait_done("t5 B", 1'b1, 10);
    step();
    clear_inputs();

    // test 6: latency sweep on all three instances with one A load
    rst = 0;
    step();
    begin
      int w1, w2, w15, d1, d2, d15;
      w1 = 0; w2 = 0; w15 = 0; d1 = 0; d2 = 0; d15 = 0;
      rst = 1; a_req = 1; a_addr = 32'h60; mem_rdata = 32'hCAFEF00D;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (d1 == 0 && s1_mem_read) w1++;
        if (d2 == 0 && mem_read) w2++;
        if (d15 == 0 && s15_mem_read) w15++;
        if (d1 == 0 && s1_a_done) d1 = k;
        if (d2 == 0 && a_done) d2 = k;
        if (d15 == 0 && s15_a_done) d15 = k;
      end
      chk("t6 L1 strobe width", w1, 32'd1);
      chk("t6 L1 done cycle", d1, 32'd2);
      chk("t6 L2 strobe width", w2, 32'd2);
      chk("t6 L2 done cycle", d2, 32'd3);
      chk("t6 L15 strobe width", w15, 32'd15);
      chk("t6 L15 done cycle", d15, 32'd16);
      chk("t6 L15 rdata", s15_a_rdata, 32'hCAFEF00D);
    end
    step();
    clear_inputs();
    step();

    chk("no strobe or done overlap", overlap, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end
endmodule
`default_nettype wire
